// File: rtl/fpu_mult_pipe_if.sv
// Request/result bundle between an issuing unit and the pipelined FP multiplier.
// The issuer uses the master view and the multiplier uses the slave view.
interface fpu_mult_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int DEST_W = 5
);
  logic                    fpu_mult_start;
  logic                    fpu_mult_ready;
  logic [EXP_W+MANT_W:0]   fpu_a;
  logic [EXP_W+MANT_W:0]   fpu_b;
  logic [DEST_W-1:0]       fpu_dest;
  logic                    mult_stall;
  logic                    mult_flush;
  logic                    mult_valid;
  logic [MANT_W+3:0]       mult_mantissa;
  logic [EXP_W-1:0]        mult_exponent;
  logic                    mult_sign;
  logic                    mult_nan;
  logic                    mult_inf;
  logic                    mult_zero;
  logic [DEST_W-1:0]       mult_dest;

  modport master (
    output fpu_mult_start, fpu_a, fpu_b, fpu_dest, mult_stall, mult_flush,
    input  fpu_mult_ready, mult_valid, mult_mantissa, mult_exponent, mult_sign,
           mult_nan, mult_inf, mult_zero, mult_dest
  );

  modport slave (
    input  fpu_mult_start, fpu_a, fpu_b, fpu_dest, mult_stall, mult_flush,
    output fpu_mult_ready, mult_valid, mult_mantissa, mult_exponent, mult_sign,
           mult_nan, mult_inf, mult_zero, mult_dest
  );
endinterface

// File: rtl/fpu_mult_pipe.sv
// Pipelined FP multiplier front half: unpack, significand product, clamped
// biased exponent and special-case classification, followed by STAGES
// register stages with stall (freeze) and flush (kill) control.
module fpu_mult_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int STAGES = 3,
  parameter int DEST_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  fpu_mult_pipe_if.slave  bus
);

  localparam int SIG_W  = MANT_W + 1;
  localparam int PROD_W = 2 * MANT_W + 2;
  localparam int OUT_W  = MANT_W + 4;
  localparam int XW     = EXP_W + 2;
  localparam int PAY_W  = OUT_W + EXP_W + 4 + DEST_W;

  localparam logic [XW-1:0]    BIAS      = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] QNAN_MANT = {1'b0, 2'b11, {(MANT_W+1){1'b0}}};

  // operand fields
  logic                 sign_a_s, sign_b_s;
  logic [EXP_W-1:0]     exp_a_s, exp_b_s;
  logic [MANT_W-1:0]    frac_a_s, frac_b_s;
  logic                 a_exp_zero_s, b_exp_zero_s;
  logic                 a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [SIG_W-1:0]     sig_a_s, sig_b_s;
  logic [XW-1:0]        eff_a_s, eff_b_s, exp_sum_s;
  logic [EXP_W-1:0]     exp_clamp_s;
  logic [OUT_W-1:0]     mant_prod_s;

  // stage-0 result
  logic [OUT_W-1:0]     res_mant_s;
  logic [EXP_W-1:0]     res_exp_s;
  logic                 res_sign_s, res_nan_s, res_inf_s, res_zero_s;
  logic [PAY_W-1:0]     pay_s;

  // pipeline state
  logic [STAGES-1:0]    valid_r;
  logic [PAY_W-1:0]     pay_r [STAGES];

  // Unpack both operands, form product and clamped exponent, then classify.
  always_comb begin
    sign_a_s     = bus.fpu_a[EXP_W+MANT_W];
    sign_b_s     = bus.fpu_b[EXP_W+MANT_W];
    exp_a_s      = bus.fpu_a[MANT_W +: EXP_W];
    exp_b_s      = bus.fpu_b[MANT_W +: EXP_W];
    frac_a_s     = bus.fpu_a[MANT_W-1:0];
    frac_b_s     = bus.fpu_b[MANT_W-1:0];
    a_exp_zero_s = (exp_a_s == {EXP_W{1'b0}});
    b_exp_zero_s = (exp_b_s == {EXP_W{1'b0}});
    a_nan_s      = (&exp_a_s) && (frac_a_s != {MANT_W{1'b0}});
    b_nan_s      = (&exp_b_s) && (frac_b_s != {MANT_W{1'b0}});
    a_inf_s      = (&exp_a_s) && (frac_a_s == {MANT_W{1'b0}});
    b_inf_s      = (&exp_b_s) && (frac_b_s == {MANT_W{1'b0}});
    a_zero_s     = a_exp_zero_s && (frac_a_s == {MANT_W{1'b0}});
    b_zero_s     = b_exp_zero_s && (frac_b_s == {MANT_W{1'b0}});

    // denormals get hidden bit 0 and effective exponent 1
    sig_a_s = {~a_exp_zero_s, frac_a_s};
    sig_b_s = {~b_exp_zero_s, frac_b_s};
    eff_a_s = a_exp_zero_s ? {{(XW-1){1'b0}}, 1'b1} : {2'b00, exp_a_s};
    eff_b_s = b_exp_zero_s ? {{(XW-1){1'b0}}, 1'b1} : {2'b00, exp_b_s};

    // keep the top OUT_W bits of the full product; the shift leaves exactly OUT_W
    mant_prod_s = OUT_W'((PROD_W'(sig_a_s) * PROD_W'(sig_b_s)) >> (MANT_W - 2));

    // two guard bits make the signed sum wrap-free: top bit = negative
    exp_sum_s = eff_a_s + eff_b_s - BIAS;
    if (exp_sum_s[XW-1]) begin
      exp_clamp_s = {EXP_W{1'b0}};
    end else if (exp_sum_s[XW-2]) begin
      exp_clamp_s = {EXP_W{1'b1}};
    end else begin
      exp_clamp_s = exp_sum_s[EXP_W-1:0];
    end

    res_nan_s  = 1'b0;
    res_inf_s  = 1'b0;
    res_zero_s = 1'b0;
    res_sign_s = sign_a_s ^ sign_b_s;
    res_exp_s  = exp_clamp_s;
    res_mant_s = mant_prod_s;
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
      res_nan_s  = 1'b1;
      res_sign_s = 1'b0;
      res_exp_s  = {EXP_W{1'b1}};
      res_mant_s = QNAN_MANT;
    end else if (a_inf_s || b_inf_s) begin
      res_inf_s  = 1'b1;
      res_exp_s  = {EXP_W{1'b1}};
      res_mant_s = {OUT_W{1'b0}};
    end else if (a_zero_s || b_zero_s) begin
      res_zero_s = 1'b1;
      res_exp_s  = {EXP_W{1'b0}};
      res_mant_s = {OUT_W{1'b0}};
    end else begin
      res_nan_s  = 1'b0;
    end

    pay_s = {res_mant_s, res_exp_s, res_sign_s, res_nan_s, res_inf_s, res_zero_s,
             bus.fpu_dest};
  end

  // Stage shift register: flush kills valid bits, stall freezes everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        pay_r[i] <= {PAY_W{1'b0}};
      end
    end else if (bus.mult_flush) begin
      valid_r <= {STAGES{1'b0}};
    end else if (!bus.mult_stall) begin
      valid_r[0] <= bus.fpu_mult_start;
      pay_r[0]   <= pay_s;
      for (int i = 1; i < STAGES; i++) begin
        valid_r[i] <= valid_r[i-1];
        pay_r[i]   <= pay_r[i-1];
      end
    end
  end

  assign bus.fpu_mult_ready = ~bus.mult_stall;
  assign bus.mult_valid     = valid_r[STAGES-1];
  assign {bus.mult_mantissa, bus.mult_exponent, bus.mult_sign, bus.mult_nan,
          bus.mult_inf, bus.mult_zero, bus.mult_dest} = pay_r[STAGES-1];

endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Directed self-checking bench for fpu_mult_pipe: arithmetic vectors, specials,
// stall, flush, async reset, and a latency sweep over STAGES = 1..4.
module tb_fpu_mult_pipe;

  localparam logic [31:0] OP_1P5 = 32'h3FC00000;
  localparam logic [31:0] OP_2P0 = 32'h40000000;
  localparam logic [31:0] OP_1P0 = 32'h3F800000;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  fpu_mult_pipe_if #(.EXP_W(8), .MANT_W(23), .DEST_W(5)) bus  ();
  fpu_mult_pipe_if #(.EXP_W(8), .MANT_W(23), .DEST_W(5)) bus1 ();
  fpu_mult_pipe_if #(.EXP_W(8), .MANT_W(23), .DEST_W(5)) bus2 ();
  fpu_mult_pipe_if #(.EXP_W(8), .MANT_W(23), .DEST_W(5)) bus4 ();

  fpu_mult_pipe #(.EXP_W(8), .MANT_W(23), .STAGES(3), .DEST_W(5))
    dut  (.clock(clock), .reset(reset), .bus(bus));
  fpu_mult_pipe #(.EXP_W(8), .MANT_W(23), .STAGES(1), .DEST_W(5))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));
  fpu_mult_pipe #(.EXP_W(8), .MANT_W(23), .STAGES(2), .DEST_W(5))
    dut2 (.clock(clock), .reset(reset), .bus(bus2));
  fpu_mult_pipe #(.EXP_W(8), .MANT_W(23), .STAGES(4), .DEST_W(5))
    dut4 (.clock(clock), .reset(reset), .bus(bus4));

  // sweep instances see the same request stream as the main instance
  assign bus1.fpu_mult_start = bus.fpu_mult_start;
  assign bus1.fpu_a          = bus.fpu_a;
  assign bus1.fpu_b          = bus.fpu_b;
  assign bus1.fpu_dest       = bus.fpu_dest;
  assign bus1.mult_stall     = bus.mult_stall;
  assign bus1.mult_flush     = bus.mult_flush;
  assign bus2.fpu_mult_start = bus.fpu_mult_start;
  assign bus2.fpu_a          = bus.fpu_a;
  assign bus2.fpu_b          = bus.fpu_b;
  assign bus2.fpu_dest       = bus.fpu_dest;
  assign bus2.mult_stall     = bus.mult_stall;
  assign bus2.mult_flush     = bus.mult_flush;
  assign bus4.fpu_mult_start = bus.fpu_mult_start;
  assign bus4.fpu_a          = bus.fpu_a;
  assign bus4.fpu_b          = bus.fpu_b;
  assign bus4.fpu_dest       = bus.fpu_dest;
  assign bus4.mult_stall     = bus.mult_stall;
  assign bus4.mult_flush     = bus.mult_flush;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] out_main();
    return {19'd0, bus.mult_valid, bus.mult_mantissa, bus.mult_exponent, bus.mult_sign,
            bus.mult_nan, bus.mult_inf, bus.mult_zero, bus.mult_dest};
  endfunction

  // Issue one op, wait (bounded) for its result and check every field.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic [26:0] em, input logic [7:0] ee,
                        input logic es, input logic [2:0] ef);
    int lat;
    bus.fpu_a          = a;
    bus.fpu_b          = b;
    bus.fpu_dest       = dest;
    bus.fpu_mult_start = 1'b1;
    tick();
    bus.fpu_mult_start = 1'b0;
    lat = 1;
    while (!bus.mult_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},   64'(lat), 64'd3);
    check({tag, "_mant"},  64'(bus.mult_mantissa), 64'(em));
    check({tag, "_exp"},   64'(bus.mult_exponent), 64'(ee));
    check({tag, "_sign"},  64'(bus.mult_sign), 64'(es));
    check({tag, "_flags"}, 64'({bus.mult_nan, bus.mult_inf, bus.mult_zero}), 64'(ef));
    check({tag, "_dest"},  64'(bus.mult_dest), 64'(dest));
    tick();
    check({tag, "_pulse"}, 64'(bus.mult_valid), 64'd0);
  endtask

  // Bounded overall run time.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [4:0]  got_q[$];
    logic [63:0] snap;
    logic        acc;
    int          pend;
    int          nvalid;
    int          l1, l2, l3, l4;
    logic [63:0] r1, r2, r3, r4;
    logic [63:0] basic_res;

    reset              = 1'b1;
    bus.fpu_mult_start = 1'b0;
    bus.fpu_a          = 32'h0;
    bus.fpu_b          = 32'h0;
    bus.fpu_dest       = 5'd0;
    bus.mult_stall     = 1'b0;
    bus.mult_flush     = 1'b0;
    #2;
    check("rst_outputs", out_main(), 64'd0);
    check("rst_ready", 64'(bus.fpu_mult_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // arithmetic and special-case vectors (flags = {nan, inf, zero})
    run_op("basic",   OP_1P5,        OP_2P0,        5'd5,  27'h3000000, 8'h80, 1'b0, 3'b000);
    run_op("ovf",     32'h7F000000,  32'h7F000000,  5'd6,  27'h2000000, 8'hFF, 1'b0, 3'b000);
    run_op("unf",     32'h00800000,  32'h00800000,  5'd7,  27'h2000000, 8'h00, 1'b0, 3'b000);
    run_op("denorm",  32'h00400000,  OP_1P0,        5'd8,  27'h1000000, 8'h01, 1'b0, 3'b000);
    run_op("neg",     32'hBFC00000,  OP_2P0,        5'd9,  27'h3000000, 8'h80, 1'b1, 3'b000);
    run_op("inf_x_0", 32'h7F800000,  32'h00000000,  5'd10, 27'h3000000, 8'hFF, 1'b0, 3'b100);
    run_op("ninf",    32'hFF800000,  OP_1P0,        5'd11, 27'h0000000, 8'hFF, 1'b1, 3'b010);
    run_op("nzero",   32'h80000000,  32'h40400000,  5'd12, 27'h0000000, 8'h00, 1'b1, 3'b001);
    run_op("qnan_in", 32'h7FC00001,  32'hC0400000,  5'd13, 27'h3000000, 8'hFF, 1'b0, 3'b100);

    // stall: four ops, downstream stalls two cycles while ops 2-3 are in flight
    bus.fpu_a = OP_1P5;
    bus.fpu_b = OP_2P0;
    pend = 1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.mult_stall     = (cyc == 3 || cyc == 4);
      bus.fpu_mult_start = (pend <= 4);
      bus.fpu_dest       = 5'(pend);
      #1;
      if (bus.mult_stall) check("stall_ready", 64'(bus.fpu_mult_ready), 64'd0);
      if (bus.mult_valid && !bus.mult_stall) got_q.push_back(bus.mult_dest);
      snap = out_main();
      acc  = bus.fpu_mult_start && bus.fpu_mult_ready;
      tick();
      if (acc) pend++;
      if (cyc == 3 || cyc == 4) check("stall_hold", out_main(), snap);
    end
    bus.mult_stall     = 1'b0;
    bus.fpu_mult_start = 1'b0;
    check("stall_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("stall_order", (i < got_q.size()) ? 64'(got_q[i]) : 64'd0, 64'(i + 1));
    end

    // flush with three ops in flight and a concurrent start
    bus.fpu_mult_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fpu_dest = 5'(20 + i);
      tick();
    end
    bus.fpu_dest   = 5'd23;
    bus.mult_flush = 1'b1;
    tick();
    bus.mult_flush     = 1'b0;
    bus.fpu_mult_start = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mult_valid) nvalid++;
      tick();
    end
    check("flush_quiet", 64'(nvalid), 64'd0);
    run_op("post_flush", OP_1P5, OP_2P0, 5'd24, 27'h3000000, 8'h80, 1'b0, 3'b000);

    // async reset pulse while results are streaming
    bus.fpu_mult_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fpu_dest = 5'(25 + i);
      tick();
    end
    bus.fpu_mult_start = 1'b0;
    check("pre_reset_valid", 64'(bus.mult_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", out_main(), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op("post_reset", OP_1P5, OP_2P0, 5'd28, 27'h3000000, 8'h80, 1'b0, 3'b000);

    // latency sweep over STAGES = 1, 2, 3, 4 with the basic op
    for (int i = 0; i < 6; i++) tick();
    bus.fpu_a          = OP_1P5;
    bus.fpu_b          = OP_2P0;
    bus.fpu_dest       = 5'd3;
    bus.fpu_mult_start = 1'b1;
    tick();
    bus.fpu_mult_start = 1'b0;
    l1 = 0; l2 = 0; l3 = 0; l4 = 0;
    r1 = 64'd0; r2 = 64'd0; r3 = 64'd0; r4 = 64'd0;
    for (int c = 1; c <= 8; c++) begin
      if (bus1.mult_valid && l1 == 0) begin
        l1 = c;
        r1 = {24'd0, bus1.mult_mantissa, bus1.mult_exponent, bus1.mult_sign,
              bus1.mult_nan, bus1.mult_inf, bus1.mult_zero};
      end
      if (bus2.mult_valid && l2 == 0) begin
        l2 = c;
        r2 = {24'd0, bus2.mult_mantissa, bus2.mult_exponent, bus2.mult_sign,
              bus2.mult_nan, bus2.mult_inf, bus2.mult_zero};
      end
      if (bus.mult_valid && l3 == 0) begin
        l3 = c;
        r3 = {24'd0, bus.mult_mantissa, bus.mult_exponent, bus.mult_sign,
              bus.mult_nan, bus.mult_inf, bus.mult_zero};
      end
      if (bus4.mult_valid && l4 == 0) begin
        l4 = c;
        r4 = {24'd0, bus4.mult_mantissa, bus4.mult_exponent, bus4.mult_sign,
              bus4.mult_nan, bus4.mult_inf, bus4.mult_zero};
      end
      tick();
    end
    basic_res = {24'd0, 27'h3000000, 8'h80, 1'b0, 3'b000};
    check("sweep_lat_s1", 64'(l1), 64'd1);
    check("sweep_lat_s2", 64'(l2), 64'd2);
    check("sweep_lat_s3", 64'(l3), 64'd3);
    check("sweep_lat_s4", 64'(l4), 64'd4);
    check("sweep_res_s1", r1, basic_res);
    check("sweep_res_s2", r2, basic_res);
    check("sweep_res_s3", r3, basic_res);
    check("sweep_res_s4", r4, basic_res);
    check("sweep_dest_s1", 64'(bus1.mult_dest), 64'd3);
    check("sweep_dest_s4", 64'(bus4.mult_dest), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_mult_pipe.md
# fpu_mult_pipe

Parametrised, pipelined floating-point multiplier front half. It is the successor to the single-cycle multiplier stage and feeds the shared FPU normalise/round stage. It unpacks two IEEE-style operands, multiplies the significands, and computes a clamped biased exponent. It also classifies NaN/Inf/zero results and carries the destination tag. All of this runs through a configurable number of register stages, with stall and flush control.

## Interface
- `EXP_W`, 8: exponent width.
- `MANT_W`, 23: stored fraction width.
- `STAGES`, 3: pipeline register stages, legal range 1..4.
- `DEST_W`, 5: destination tag width.
- `clock` input 1: single clock. All flops on rising edge.
- `reset` input 1: asynchronous, active-high.
- `fpu_mult_start` input 1: operation request.
- `fpu_mult_ready` output 1: combinational `~mult_stall`. An op is accepted on an edge where `fpu_mult_start && fpu_mult_ready`.
- `fpu_a`, `fpu_b` input 1+EXP_W+MANT_W: operands as {sign, exp, frac}.
- `fpu_dest` input DEST_W: destination tag.
- `mult_stall` input 1: downstream back-pressure. Freezes every stage.
- `mult_flush` input 1: kill all in-flight ops.
- `mult_valid` output 1: result valid.
- `mult_mantissa` output MANT_W+4: product bits [2·MANT_W+1 : MANT_W−2]. Bit MANT_W+2 is the 2^0 position.
- `mult_exponent` output EXP_W: clamped biased exponent.
- `mult_sign` output 1: result sign.
- `mult_nan`, `mult_inf`, `mult_zero` output 1: special-result flags, at most one set.
- `mult_dest` output DEST_W: tag of the result.

## Operation
- Unpack each operand.
  - exp==0 gives hidden bit 0 and effective exponent 1.
  - Otherwise hidden bit is 1 and effective exponent is exp.
- Significand product: unsigned (MANT_W+1)×(MANT_W+1) giving 2·MANT_W+2 bits. The multiply may be split or retimed across stages; only the output boundary is specified.
- Exponent is computed as the signed value S = effA + effB − BIAS, where BIAS = 2^(EXP_W−1)−1. Width is EXP_W+2 (no wrap).
  - S<0 gives exponent 0 (underflow). Mantissa is unchanged.
  - S>2^EXP_W−1 gives all-ones (overflow). Mantissa is unchanged and no flag is set.
- Sign = signA ^ signB, except on NaN.
- Classification, in priority order:
  1. **NaN:** either operand is NaN (exp all-ones, frac≠0), or Inf×zero.
     - Outputs: sign 0, exponent all-ones.
     - Mantissa bits MANT_W+2 and MANT_W+1 set, all others 0 (quiet NaN).
     - `mult_nan`=1.
  2. **Inf:** either operand is Inf.
     - Outputs: exponent all-ones, mantissa 0, `mult_inf`=1.
  3. **Zero:** either operand has exp 0 and frac 0.
     - Outputs: exponent 0, mantissa 0, `mult_zero`=1.
  4. **Normal/denormal:** computed values, all flags 0.
- Each stage holds a valid bit plus payload. The payload of an invalid stage is don't-care, except at reset.
- **Stall:** while `mult_stall`=1, no stage updates, including the output stage. Outputs are held exactly and no op is accepted.
- **Flush:** `mult_flush`=1 at an edge clears every stage valid bit. Flush has priority over stall and over a simultaneous start, so an op presented in the flush cycle is discarded.
- Ordering: results emerge in acceptance order with no loss or duplication across any stall pattern.

## Timing
- Op accepted at edge k, no stall: outputs carry it after edge k+STAGES−1. With STAGES=1, outputs are registered on the accepting edge.
- Each stall cycle adds exactly one cycle of latency to every in-flight op.
- Throughput is one op per cycle when not stalled.
- `mult_valid` is high for one cycle per op, longer only while stalled.
- **Reset:** all valid bits 0. `mult_valid`, `mult_mantissa`, `mult_exponent`, `mult_sign`, the three flags, and `mult_dest` are all 0.
  - Reset mid-operation discards all in-flight ops immediately (asynchronous).
  - The first op is accepted on the first edge after deassertion.
- `fpu_mult_ready` depends only on `mult_stall`, with no path from `fpu_mult_start`.

## Test plan
- **Basic multiply.** Defaults. a=0x3FC00000 (1.5), b=0x40000000 (2.0), single op.
  - Expect `mult_valid` 3 cycles after acceptance.
  - mantissa=0x3000000, exponent=0x80, sign=0, flags 0, dest echoed.
- **Overflow / underflow clamp.**
  - 0x7F000000×0x7F000000 → exponent 0xFF, mantissa 0x2000000, flags 0.
  - 0x00800000×0x00800000 → exponent 0x00, mantissa 0x2000000.
- **Specials.**
  - 0x7F800000×0x00000000 → `mult_nan`, sign 0, exponent 0xFF, mantissa 0x3000000.
  - 0xFF800000×0x3F800000 → `mult_inf`, sign 1, mantissa 0.
  - 0x80000000×0x40400000 → `mult_zero`, sign 1.
  - 0x7FC00001×anything → `mult_nan`.
- **Stall.** Four back-to-back ops with dest 1..4. Assert `mult_stall` for 2 cycles while ops 2–3 are in flight.
  - Dests emerge 1,2,3,4 exactly once each.
  - Outputs are frozen during the stall and `fpu_mult_ready`=0.
- **Flush and reset.**
  - Flush with 3 ops in flight plus a concurrent start: no `mult_valid` follows, and the next op after flush has normal latency.
  - Async reset pulse mid-stream: all outputs read 0 immediately.
- **Parameter sweep.** STAGES=1, 2, 4 with the basic-multiply op: latency equals STAGES and results are identical.
